// File: rtl/regfile_sb_pkg.sv
// -----------------------------------------------------------------------------
// regfile_sb_pkg
// Shared constants, types and helpers for the scoreboarded register file.
//   DEFAULT_DATA_W / DEFAULT_NUM_REGS : default parameter values
//   reg_addr_t / reg_data_t           : address/data types at the defaults
//   addr_in_range()                   : true when an address maps to a register
// -----------------------------------------------------------------------------
package regfile_sb_pkg;

  localparam int DEFAULT_DATA_W   = 8;
  localparam int DEFAULT_NUM_REGS = 4;

  typedef logic [$clog2(DEFAULT_NUM_REGS)-1:0] reg_addr_t;
  typedef logic [DEFAULT_DATA_W-1:0]           reg_data_t;

  // Addresses are zero-extended to 32 bits by the caller, so any ADDR_W works.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input int unsigned num_regs);
    return addr < num_regs;
  endfunction

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_sb_scoreboard
// One busy bit per register plus two registered lookups for the read ports.
// Reserve (set) has priority over write-completion (clear) on the same register.
// Lookups report the busy state after the current edge's set/clear.
// Ports:
//   clk, rst_n              : clock, synchronous active-low reset
//   i_set_en / i_set_addr   : reserve strobe and register (already qualified)
//   i_clr_en / i_clr_addr   : write strobe and register (already qualified)
//   i_rd_en, i_rs, i_rt     : read request and the two read addresses
//   o_rs_busy, o_rt_busy    : registered busy flags for the read addresses
// -----------------------------------------------------------------------------
module regfile_sb_scoreboard
  import regfile_sb_pkg::*;
#(
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_set_en,
  input  logic [ADDR_W-1:0] i_set_addr,
  input  logic              i_clr_en,
  input  logic [ADDR_W-1:0] i_clr_addr,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rs,
  input  logic [ADDR_W-1:0] i_rt,
  output logic              o_rs_busy,
  output logic              o_rt_busy
);

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busy_nxt;
  logic                r_rs_busy;
  logic                r_rt_busy;

  always_comb begin
    // NOTE: start from a full default so every path assigns w_busy_nxt and no latch is inferred.
    w_busy_nxt = r_busy;
    if (i_clr_en) w_busy_nxt[i_clr_addr] = 1'b0;
    // Applied after the clear so a same-register reserve wins.
    if (i_set_en) w_busy_nxt[i_set_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values, independent of statement order.
    if (!rst_n) begin
      r_busy    <= '0;
      r_rs_busy <= 1'b0;
      r_rt_busy <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      if (i_rd_en) begin
        r_rs_busy <= addr_in_range(32'(i_rs), NUM_REGS) ? w_busy_nxt[i_rs] : 1'b0;
        r_rt_busy <= addr_in_range(32'(i_rt), NUM_REGS) ? w_busy_nxt[i_rt] : 1'b0;
      end
    end
  end

  assign o_rs_busy = r_rs_busy;
  assign o_rt_busy = r_rt_busy;

endmodule

// File: rtl/regfile_sb.sv
// -----------------------------------------------------------------------------
// regfile_sb
// Two-read / one-write register file with a busy-bit scoreboard.
// Reads have one-cycle latency and are write-first: a read of the register
// written on the same edge returns the new data. Read outputs hold while
// rd_en is low. Out-of-range addresses read as 0 / not busy, and writes or
// reserves to them are dropped.
// Optional feature: define REGFILE_SB_ZERO_REG_EN to hard-wire register 0 to
// zero (writes and reserves to it are ignored, busy[0] stays 0).
// Ports:
//   clk, rst_n                 : clock, synchronous active-low reset
//   rd_en, rs, rt              : read request and addresses (ports A/B)
//   rs_val, rt_val             : registered read data
//   rs_busy, rt_busy           : registered busy flags of the read registers
//   rd_valid                   : rd_en delayed by one cycle
//   is_write, reg_write, write_val : write strobe, address and data
//   resv_en, resv_reg          : reserve strobe and register
// -----------------------------------------------------------------------------
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  output logic [DATA_W-1:0] rs_val,
  output logic [DATA_W-1:0] rt_val,
  output logic              rs_busy,
  output logic              rt_busy,
  output logic              rd_valid,
  input  logic              is_write,
  input  logic [ADDR_W-1:0] reg_write,
  input  logic [DATA_W-1:0] write_val,
  input  logic              resv_en,
  input  logic [ADDR_W-1:0] resv_reg
);

`ifdef REGFILE_SB_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic [DATA_W-1:0] r_rs_val;
  logic [DATA_W-1:0] r_rt_val;
  logic              r_rd_valid;

  logic              w_wr_ok;
  logic              w_resv_ok;
  logic [DATA_W-1:0] w_rs_data;
  logic [DATA_W-1:0] w_rt_data;

  // Qualified strobes: in range, and not the hard-wired zero register.
  // With register 0 never written, its reads (including bypass) stay 0.
  assign w_wr_ok   = is_write && addr_in_range(32'(reg_write), NUM_REGS)
                     && !(ZERO_REG && (reg_write == '0));
  assign w_resv_ok = resv_en && addr_in_range(32'(resv_reg), NUM_REGS)
                     && !(ZERO_REG && (resv_reg == '0));

  // Write-first read muxes.
  always_comb begin
    w_rs_data = '0;
    w_rt_data = '0;
    if (addr_in_range(32'(rs), NUM_REGS))
      w_rs_data = (w_wr_ok && (reg_write == rs)) ? write_val : r_regs[rs];
    if (addr_in_range(32'(rt), NUM_REGS))
      w_rt_data = (w_wr_ok && (reg_write == rt)) ? write_val : r_regs[rt];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the register array is reset explicitly because the architecture defines registers as 0 after reset.
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      r_rs_val   <= '0;
      r_rt_val   <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      if (w_wr_ok) r_regs[reg_write] <= write_val;
      r_rd_valid <= rd_en;
      if (rd_en) begin
        r_rs_val <= w_rs_data;
        r_rt_val <= w_rt_data;
      end
    end
  end

  regfile_sb_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_set_en   (w_resv_ok),
    .i_set_addr (resv_reg),
    .i_clr_en   (w_wr_ok),
    .i_clr_addr (reg_write),
    .i_rd_en    (rd_en),
    .i_rs       (rs),
    .i_rt       (rt),
    .o_rs_busy  (rs_busy),
    .o_rt_busy  (rt_busy)
  );

  assign rs_val   = r_rs_val;
  assign rt_val   = r_rt_val;
  assign rd_valid = r_rd_valid;

endmodule

// File: tb/tb_regfile_sb.sv
// -----------------------------------------------------------------------------
// tb_regfile_sb
// Scoreboard bench for regfile_sb with 6 registers (3-bit addresses, so
// addresses 6 and 7 are out of range). The stimulus process updates an
// array-based reference model at each edge and queues the expected read
// response; a separate monitor pops and compares whenever rd_valid is high,
// and checks reset and hold behaviour on the other cycles.
// -----------------------------------------------------------------------------
module tb_regfile_sb;
  import regfile_sb_pkg::*;

  localparam int NREGS = 6;
  localparam int AW    = 3;
  localparam int DW    = 8;

`ifdef REGFILE_SB_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rd_en;
  logic [AW-1:0] rs, rt;
  reg_data_t     rs_val, rt_val;
  logic          rs_busy, rt_busy, rd_valid;
  logic          is_write;
  logic [AW-1:0] reg_write;
  reg_data_t     write_val;
  logic          resv_en;
  logic [AW-1:0] resv_reg;

  regfile_sb #(.DATA_W(DW), .NUM_REGS(NREGS), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_en     (rd_en),
    .rs        (rs),
    .rt        (rt),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .rs_busy   (rs_busy),
    .rt_busy   (rt_busy),
    .rd_valid  (rd_valid),
    .is_write  (is_write),
    .reg_write (reg_write),
    .write_val (write_val),
    .resv_en   (resv_en),
    .resv_reg  (resv_reg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    reg_data_t rs_val;
    reg_data_t rt_val;
    logic      rs_busy;
    logic      rt_busy;
  } exp_t;

  exp_t      exp_q[$];
  reg_data_t m_regs [NREGS];
  bit        m_busy [NREGS];
  int        n_checks = 0;
  int        n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit modifiable(input logic [AW-1:0] a);
    return (int'(a) < NREGS) && !(ZERO_REG && (a == '0));
  endfunction

  function automatic reg_data_t m_read(input logic [AW-1:0] a);
    return (int'(a) < NREGS) ? m_regs[a] : '0;
  endfunction

  function automatic bit m_busy_of(input logic [AW-1:0] a);
    return (int'(a) < NREGS) ? m_busy[a] : 1'b0;
  endfunction

  // Reference model: apply this edge's write and reserve (reserve last, so it
  // wins), then a read observes the post-edge state.
  task automatic model_edge();
    exp_t e;
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        m_regs[i] = '0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (is_write && modifiable(reg_write)) begin
        m_regs[reg_write] = write_val;
        m_busy[reg_write] = 1'b0;
      end
      if (resv_en && modifiable(resv_reg)) m_busy[resv_reg] = 1'b1;
      if (rd_en) begin
        e.rs_val  = m_read(rs);
        e.rt_val  = m_read(rt);
        e.rs_busy = m_busy_of(rs);
        e.rt_busy = m_busy_of(rt);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic drive(input bit rst, input bit rd, input logic [AW-1:0] a_rs,
                       input logic [AW-1:0] a_rt, input bit wr, input logic [AW-1:0] wa,
                       input reg_data_t wv, input bit rv, input logic [AW-1:0] ra);
    @(negedge clk);
    rst_n     = rst;
    rd_en     = rd;
    rs        = a_rs;
    rt        = a_rt;
    is_write  = wr;
    reg_write = wa;
    write_val = wv;
    resv_en   = rv;
    resv_reg  = ra;
    model_edge();
    @(posedge clk);
  endtask

  // Monitor
  initial begin
    exp_t e;
    exp_t last_seen;
    last_seen = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        check("reset_rd_valid", 64'(rd_valid), 64'd0);
        check("reset_outputs", 64'({rs_val, rt_val, rs_busy, rt_busy}), 64'd0);
        last_seen = '0;
      end else if (rd_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_rd_valid", 64'(rd_valid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("rs_val",  64'(rs_val),  64'(e.rs_val));
          check("rt_val",  64'(rt_val),  64'(e.rt_val));
          check("rs_busy", 64'(rs_busy), 64'(e.rs_busy));
          check("rt_busy", 64'(rt_busy), 64'(e.rt_busy));
          last_seen = e;
        end
      end else begin
        check("hold_outputs", 64'({rs_val, rt_val, rs_busy, rt_busy}), 64'(last_seen));
      end
    end
  end

  // Stimulus
  initial begin
    rst_n = 1'b0; rd_en = 1'b0; rs = '0; rt = '0;
    is_write = 1'b0; reg_write = '0; write_val = '0;
    resv_en = 1'b0; resv_reg = '0;

    //    rst rd rs rt  wr wa wv     rv ra
    drive(0, 0, 0, 0,  0, 0, 8'h00, 0, 0);
    drive(0, 1, 1, 2,  1, 1, 8'h99, 1, 1);   // everything ignored in reset
    drive(1, 1, 0, 3,  0, 0, 8'h00, 0, 0);   // first read after release
    drive(1, 0, 0, 0,  1, 2, 8'hA5, 0, 0);   // write r2
    drive(1, 1, 2, 0,  0, 0, 8'h00, 0, 0);   // read r2
    drive(1, 1, 1, 1,  1, 1, 8'h3C, 0, 0);   // bypass, rs = rt
    drive(1, 0, 0, 0,  0, 0, 8'h00, 1, 3);   // reserve r3
    drive(1, 1, 0, 3,  0, 0, 8'h00, 0, 0);   // rt_busy = 1
    drive(1, 1, 0, 3,  1, 3, 8'h11, 0, 0);   // write clears busy, bypass data
    drive(1, 0, 0, 0,  1, 2, 8'h77, 1, 2);   // reserve wins, data commits
    drive(1, 1, 2, 2,  0, 0, 8'h00, 0, 0);
    drive(1, 0, 0, 0,  1, 0, 8'hFF, 1, 0);   // r0 write + reserve
    drive(1, 1, 0, 4,  0, 0, 8'h00, 0, 0);
    drive(1, 0, 0, 0,  1, 6, 8'h55, 1, 7);   // out-of-range write / reserve
    drive(1, 1, 6, 7,  1, 7, 8'hEE, 0, 0);   // out-of-range reads
    drive(1, 0, 5, 5,  1, 5, 8'h12, 0, 0);   // hold while rd_en = 0
    drive(1, 1, 5, 2,  0, 0, 8'h00, 0, 0);
    drive(0, 1, 1, 2,  0, 0, 8'h00, 0, 0);   // reset mid-operation
    drive(1, 1, 2, 1,  0, 0, 8'h00, 0, 0);

    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 59) != 0), $urandom_range(0, 1) == 1,
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), 8'($urandom),
            $urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)));
    end

    for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0, 0, 8'h00, 0, 0);
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
